dram_rw_scheduler: RTL

//  Read/write command scheduler between the frontend and the DRAM command backend. Reads issue

---
 rtl/dram_rw_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dram_rw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_rw_scheduler: read-priority DRAM command scheduler with watermark      |
// | write drain, starvation bounds and read-after-write hazard blocking.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dram_rw_scheduler #(
  parameter int ADDR_W    = 24,
  parameter int WQ_DEPTH  = 16,
  parameter int HI_WM     = 12,
  parameter int LO_WM     = 4,
  parameter int WR_STARVE = 64,
  parameter int RD_STARVE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rd_valid,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic                      o_rd_ready,
  input  logic                      i_wr_push,
  input  logic                      i_wq_empty,
  input  logic [ADDR_W-1:0]         i_wq_head,
  input  logic [8*(ADDR_W+1)-1:0]   i_wq_pend,
  output logic                      o_wq_pop,
  output logic                      o_cmd_valid,
  output logic                      o_cmd_write,
  output logic [ADDR_W-1:0]         o_cmd_addr,
  input  logic                      i_cmd_ready,
  output logic [1:0]                o_state,
  output logic [$clog2(WQ_DEPTH):0] o_wr_count
);

  localparam int CNT_W  = $clog2(WQ_DEPTH) + 1;
  localparam int AGE_W  = $clog2(WR_STARVE) + 1;
  localparam int WAIT_W = $clog2(RD_STARVE) + 1;

  localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(WQ_DEPTH);
  localparam logic [CNT_W-1:0]  c_hi_wm    = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0]  c_lo_wm    = CNT_W'(LO_WM);
  localparam logic [AGE_W-1:0]  c_age_max  = AGE_W'(WR_STARVE - 1);
  localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(RD_STARVE - 1);

  typedef enum logic [1:0] {
    S_READ   = 2'b00,
    S_DRAIN  = 2'b01,
    S_HAZARD = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_wr_count;
  logic [AGE_W-1:0]    r_wr_age;
  logic [WAIT_W-1:0]   r_rd_wait;
  logic                r_cmd_valid;
  logic                r_cmd_write;
  logic [ADDR_W-1:0]   r_cmd_addr;

  logic [7:0]          w_match;
  logic                w_hazard;
  logic                w_free;
  logic                w_rd_issue;
  logic                w_wr_issue;
  logic                w_age_hit;
  logic                w_wait_hit;

  // Full-address compare of the read against each valid pending write entry
  for (genvar k = 0; k < 8; k++) begin : g_pend
    assign w_match[k] = i_wq_pend[k*(ADDR_W+1) + ADDR_W] &&
                        (i_wq_pend[k*(ADDR_W+1) +: ADDR_W] == i_rd_addr);
  end

  assign w_hazard   = i_rd_valid && (|w_match);
  assign w_free     = !r_cmd_valid || i_cmd_ready;
  assign w_age_hit  = (r_wr_age == c_age_max);
  assign w_wait_hit = (r_rd_wait == c_wait_max);

  // Handshakes are masked by reset so an asserted i_rst_n clears them immediately
  assign w_rd_issue = i_rst_n && (r_state == S_READ) && i_rd_valid && !w_hazard && w_free;
  assign w_wr_issue = i_rst_n && (r_state != S_READ) && w_free && !i_wq_empty;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_READ: begin
        if (w_hazard)                                w_next = S_HAZARD;
        else if ((r_wr_count >= c_hi_wm) || w_age_hit) w_next = S_DRAIN;
      end
      S_HAZARD: begin
        if (!w_hazard) w_next = S_READ;
      end
      S_DRAIN: begin
        if (w_hazard && w_wait_hit) w_next = S_HAZARD;
        else if ((r_wr_count <= c_lo_wm) || (r_wr_count == '0) || w_wait_hit)
          w_next = S_READ;
      end
      default: w_next = S_READ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_READ;
      r_wr_count  <= '0;
      r_wr_age    <= '0;
      r_rd_wait   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
    end else begin
      r_state <= w_next;

      case ({i_wr_push, w_wr_issue})
        2'b10:   if (r_wr_count != c_depth) r_wr_count <= r_wr_count + 1'b1;
        2'b01:   if (r_wr_count != '0)      r_wr_count <= r_wr_count - 1'b1;
        default: r_wr_count <= r_wr_count;
      endcase

      if ((r_state == S_READ) && (w_next == S_READ) && (r_wr_count != '0))
        r_wr_age <= r_wr_age + 1'b1;
      else
        r_wr_age <= '0;

      if ((r_state == S_DRAIN) && (w_next == S_DRAIN) && i_rd_valid)
        r_rd_wait <= r_rd_wait + 1'b1;
      else
        r_rd_wait <= '0;

      if (w_rd_issue) begin
        r_cmd_valid <= 1'b1;
        r_cmd_write <= 1'b0;
        r_cmd_addr  <= i_rd_addr;
      end else if (w_wr_issue) begin
        r_cmd_valid <= 1'b1;
        r_cmd_write <= 1'b1;
        r_cmd_addr  <= i_wq_head;
      end else if (w_free) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign o_rd_ready  = w_rd_issue;
  assign o_wq_pop    = w_wr_issue;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_write = r_cmd_write;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_state     = r_state;
  assign o_wr_count  = r_wr_count;

endmodule
`default_nettype wire
